// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register write arbiter and its round-robin picker.
package reg_arb_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_HOLD_MAX = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first unmasked request at or after ptr_i, wrapping N-1 -> 0.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [N-1:0]  elig;
    logic [IW-1:0] sel;
    int            idx;

    assign elig = req_i & ~mask_i;

    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) idx = idx - N;
            sel = IW'(idx);
            if (!gnt_vld_o && elig[sel]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = sel;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register write port among NUM_REQ valid/ready requesters.
// Optional REG_ARB_HOLD_EN adds req_hold_i so an owner can keep the port for up to HOLD_MAX writes.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_data_i,
`ifdef REG_ARB_HOLD_EN
    input  logic [NUM_REQ-1:0]               req_hold_i,
`endif
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic                             reg_en_o,
    output logic [WIDTH-1:0]                 reg_in_o,
    output logic [idx_w(NUM_REQ)-1:0]        owner_o,
    output logic                             busy_o
);

    localparam int IW = idx_w(NUM_REQ);

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;

    logic [IW-1:0]        nxt_ptr;
    logic [IW-1:0]        pick_ptr;
    logic [NUM_REQ-1:0]   pick_mask;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_vld;

`ifdef REG_ARB_HOLD_EN
    localparam int HCW = $clog2(HOLD_MAX + 1);
    logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    assign nxt_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

    // While writing, the current owner is excluded and the search starts just past it.
    assign pick_ptr  = (state_q == WRITE) ? nxt_ptr : ptr_q;
    assign pick_mask = (state_q == WRITE) ? onehot(owner_q) : '0;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i     (req_valid_i),
        .mask_i    (pick_mask),
        .ptr_i     (pick_ptr),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        ready_d = '0;
`ifdef REG_ARB_HOLD_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d = WRITE;
                    owner_d = gnt_idx;
                    data_d  = req_data_i[gnt_idx];
                    ready_d = onehot(gnt_idx);
`ifdef REG_ARB_HOLD_EN
                    hold_cnt_d = HCW'(1);
`endif
                end
            end
            WRITE: begin
                ptr_d = nxt_ptr;
`ifdef REG_ARB_HOLD_EN
                if (req_hold_i[owner_q] && req_valid_i[owner_q] && (hold_cnt_q < HCW'(HOLD_MAX))) begin
                    ptr_d      = ptr_q;
                    data_d     = req_data_i[owner_q];
                    ready_d    = onehot(owner_q);
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end else
`endif
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    data_d  = req_data_i[gnt_idx];
                    ready_d = onehot(gnt_idx);
`ifdef REG_ARB_HOLD_EN
                    hold_cnt_d = HCW'(1);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            ready_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

`ifdef REG_ARB_HOLD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_cnt_q <= '0;
        else     hold_cnt_q <= hold_cnt_d;
    end
`endif

    assign reg_en_o    = (state_q == WRITE);
    assign busy_o      = (state_q == WRITE);
    assign reg_in_o    = data_q;
    assign owner_o     = owner_q;
    assign req_ready_o = ready_q;

endmodule
